// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and sequencing controller for a 5-stage pipeline. Sits beside the
// decode stage and generates the stall/flush controls for PC, IF/ID and ID/EX
// from ID, EX and MEM stage status:
//   - load-use bubbles (load in EX feeding a source register of ID)
//   - taken-branch flushes of IF/ID and ID/EX
//   - interlocks against the multi-cycle mul/div unit (issue and result read)
//   - whole-pipe freeze while the data memory has not completed an access
// It also tracks mul/div occupancy with a small IDLE/BUSY FSM and keeps a
// saturating count of cycles in which the PC was held.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   MemRead_EX        instruction in EX is a load
//   RT_EX             destination register of that load
//   RS_ID, RT_ID      source registers of the instruction in ID
//   UseRt_ID          ID instruction actually reads rt
//   BranchTaken_EX    branch/jump resolved taken in EX
//   MdStart_ID        ID instruction is mult/div
//   MdIsDiv_ID        with MdStart_ID: 1 = div, 0 = mult
//   MdRead_ID         ID instruction is mfhi/mflo
//   MemReq_MEM        MEM stage performs a load/store
//   MemReady_MEM      data memory completes this cycle
//   StallPC           hold PC
//   StallIFID         hold IF/ID
//   FlushIFID         clear IF/ID
//   FlushIDEX         insert bubble into ID/EX
//   Freeze            hold ID/EX, EX/MEM, MEM/WB
//   MdBusy            mul/div unit occupied (straight from state register)
//   MdDone            pulse in the last busy cycle of the mul/div unit
//   stall_cycles      saturating count of cycles with StallPC high
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemRead_EX,
  input  logic [4:0]       RT_EX,
  input  logic [4:0]       RS_ID,
  input  logic [4:0]       RT_ID,
  input  logic             UseRt_ID,
  input  logic             BranchTaken_EX,
  input  logic             MdStart_ID,
  input  logic             MdIsDiv_ID,
  input  logic             MdRead_ID,
  input  logic             MemReq_MEM,
  input  logic             MemReady_MEM,
  output logic             StallPC,
  output logic             StallIFID,
  output logic             FlushIFID,
  output logic             FlushIDEX,
  output logic             Freeze,
  output logic             MdBusy,
  output logic             MdDone,
  output logic [CNT_W-1:0] stall_cycles
);

  // Down-counter must hold DIV_LAT-1, the largest reload value.
  localparam int MDC_W = $clog2(DIV_LAT + 1);

  localparam logic [MDC_W-1:0] MD_ZERO  = MDC_W'(0);
  localparam logic [MDC_W-1:0] MD_ONE   = MDC_W'(1);
  localparam logic [MDC_W-1:0] MUL_LOAD = MDC_W'(MUL_LAT - 1);
  localparam logic [MDC_W-1:0] DIV_LOAD = MDC_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  md_state_t        r_state;
  logic [MDC_W-1:0] r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mem_wait;
  logic w_load_use;
  logic w_md_busy;
  logic w_md_done;
  logic w_md_hz;
  logic w_issue;
  logic w_stall_pc;
  logic w_stall_ifid;
  logic w_flush_ifid;
  logic w_flush_idex;
  logic w_freeze;

  // Hazard detection terms.
  assign w_mem_wait = MemReq_MEM & ~MemReady_MEM;
  // Register 0 is hard-wired zero, so a load into it never creates a hazard.
  assign w_load_use = MemRead_EX & (RT_EX != 5'd0) &
                      ((RT_EX == RS_ID) | (UseRt_ID & (RT_EX == RT_ID)));
  assign w_md_busy  = (r_state == ST_BUSY);
  assign w_md_done  = w_md_busy & (r_md_cnt == MD_ONE);
  // In the last busy cycle the result is available next cycle, so a reader
  // or a new mul/div in ID may proceed.
  assign w_md_hz    = w_md_busy & (MdStart_ID | MdRead_ID) & ~w_md_done;

  // A mul/div issues only when the ID instruction actually advances into EX.
  assign w_issue    = MdStart_ID & ~w_mem_wait & ~BranchTaken_EX &
                      ~w_load_use & ~w_md_hz;

  // Prioritised stall/flush decode; everything held low while in reset.
  always_comb begin
    w_stall_pc   = 1'b0;
    w_stall_ifid = 1'b0;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    w_freeze     = 1'b0;
    if (!rst_n) begin
      w_stall_pc   = 1'b0;
      w_stall_ifid = 1'b0;
    end else if (w_mem_wait) begin
      // Memory stall freezes everything; a pending branch or load-use is
      // re-evaluated once the access completes.
      w_freeze     = 1'b1;
      w_stall_pc   = 1'b1;
      w_stall_ifid = 1'b1;
    end else if (BranchTaken_EX) begin
      // Wrong-path instructions in IF/ID and ID are discarded, so no stall.
      w_flush_ifid = 1'b1;
      w_flush_idex = 1'b1;
    end else if (w_load_use | w_md_hz) begin
      w_stall_pc   = 1'b1;
      w_stall_ifid = 1'b1;
      w_flush_idex = 1'b1;
    end else begin
      w_freeze     = 1'b0;
    end
  end

  // Mul/div occupancy FSM; the unit keeps counting through memory freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_md_cnt <= MD_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state  <= ST_BUSY;
            r_md_cnt <= MdIsDiv_ID ? DIV_LOAD : MUL_LOAD;
          end else begin
            r_state  <= ST_IDLE;
            r_md_cnt <= MD_ZERO;
          end
        end
        ST_BUSY: begin
          if (r_md_cnt == MD_ONE) begin
            // Back-to-back issue in the final cycle reloads without a gap.
            if (w_issue) begin
              r_state  <= ST_BUSY;
              r_md_cnt <= MdIsDiv_ID ? DIV_LOAD : MUL_LOAD;
            end else begin
              r_state  <= ST_IDLE;
              r_md_cnt <= MD_ZERO;
            end
          end else begin
            r_state  <= ST_BUSY;
            r_md_cnt <= r_md_cnt - MD_ONE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_md_cnt <= MD_ZERO;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall_pc && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign StallPC      = w_stall_pc;
  assign StallIFID    = w_stall_ifid;
  assign FlushIFID    = w_flush_ifid;
  assign FlushIDEX    = w_flush_idex;
  assign Freeze       = w_freeze;
  assign MdBusy       = w_md_busy;
  assign MdDone       = w_md_done;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pipe_hazard_ctrl. A driver applies one stimulus vector per
// cycle at the falling edge and pushes the expected outputs, computed by a
// cycle-level reference model, onto a queue. A monitor samples the DUT shortly
// afterwards (well before the rising edge) and compares against the queue.
// A narrow counter width is used so that saturation is reached.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       mem_read;
    logic [4:0] rt_ex;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       use_rt;
    logic       br;
    logic       md_start;
    logic       md_div;
    logic       md_read;
    logic       mem_req;
    logic       mem_ready;
  } stim_t;

  typedef struct packed {
    logic             spc;
    logic             sif;
    logic             fif;
    logic             fid;
    logic             frz;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             MemRead_EX = 1'b0;
  logic [4:0]       RT_EX = 5'd0;
  logic [4:0]       RS_ID = 5'd0;
  logic [4:0]       RT_ID = 5'd0;
  logic             UseRt_ID = 1'b0;
  logic             BranchTaken_EX = 1'b0;
  logic             MdStart_ID = 1'b0;
  logic             MdIsDiv_ID = 1'b0;
  logic             MdRead_ID = 1'b0;
  logic             MemReq_MEM = 1'b0;
  logic             MemReady_MEM = 1'b0;
  logic             StallPC;
  logic             StallIFID;
  logic             FlushIFID;
  logic             FlushIDEX;
  logic             Freeze;
  logic             MdBusy;
  logic             MdDone;
  logic [CNT_W-1:0] stall_cycles;

  pipe_hazard_ctrl #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .MemRead_EX    (MemRead_EX),
    .RT_EX         (RT_EX),
    .RS_ID         (RS_ID),
    .RT_ID         (RT_ID),
    .UseRt_ID      (UseRt_ID),
    .BranchTaken_EX(BranchTaken_EX),
    .MdStart_ID    (MdStart_ID),
    .MdIsDiv_ID    (MdIsDiv_ID),
    .MdRead_ID     (MdRead_ID),
    .MemReq_MEM    (MemReq_MEM),
    .MemReady_MEM  (MemReady_MEM),
    .StallPC       (StallPC),
    .StallIFID     (StallIFID),
    .FlushIFID     (FlushIFID),
    .FlushIDEX     (FlushIDEX),
    .Freeze        (Freeze),
    .MdBusy        (MdBusy),
    .MdDone        (MdDone),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model state: busy cycles remaining for the mul/div unit
  // (0 = idle) and the running stall count.
  int   md_left   = 0;
  int   stall_cnt = 0;
  exp_t exp_q[$];
  int   vectors   = 0;
  int   miscompares = 0;
  bit   drv_done  = 1'b0;

  // Apply one cycle of stimulus and record the expected response.
  task automatic apply(input stim_t s, input logic rst_v);
    exp_t e;
    bit   mem_wait, lu, hz, issue;
    @(negedge clk);
    MemRead_EX     = s.mem_read;
    RT_EX          = s.rt_ex;
    RS_ID          = s.rs_id;
    RT_ID          = s.rt_id;
    UseRt_ID       = s.use_rt;
    BranchTaken_EX = s.br;
    MdStart_ID     = s.md_start;
    MdIsDiv_ID     = s.md_div;
    MdRead_ID      = s.md_read;
    MemReq_MEM     = s.mem_req;
    MemReady_MEM   = s.mem_ready;
    rst_n          = rst_v;
    e = '0;
    if (!rst_v) begin
      md_left   = 0;
      stall_cnt = 0;
    end else begin
      mem_wait = s.mem_req && !s.mem_ready;
      lu = s.mem_read && (s.rt_ex != 5'd0) &&
           ((s.rt_ex == s.rs_id) || (s.use_rt && (s.rt_ex == s.rt_id)));
      hz = (md_left > 0) && (s.md_start || s.md_read) && (md_left != 1);
      if (mem_wait) begin
        e.spc = 1'b1; e.sif = 1'b1; e.frz = 1'b1;
      end else if (s.br) begin
        e.fif = 1'b1; e.fid = 1'b1;
      end else if (lu || hz) begin
        e.spc = 1'b1; e.sif = 1'b1; e.fid = 1'b1;
      end
      e.busy = (md_left > 0);
      e.done = (md_left == 1);
      e.cnt  = CNT_W'(stall_cnt);
      issue = s.md_start && !mem_wait && !s.br && !lu && !hz;
      if (issue) md_left = (s.md_div ? DIV_LAT : MUL_LAT) - 1;
      else if (md_left > 0) md_left = md_left - 1;
      if (e.spc && stall_cnt < CNT_MAX) stall_cnt = stall_cnt + 1;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest expected entry.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{StallPC, StallIFID, FlushIFID, FlushIDEX, Freeze,
                MdBusy, MdDone, stall_cycles};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs vec %0d: got spc%b sif%b fif%b fid%b frz%b busy%b done%b cnt%0d, want spc%b sif%b fif%b fid%b frz%b busy%b done%b cnt%0d",
                   vectors, got.spc, got.sif, got.fif, got.fid, got.frz, got.busy, got.done, got.cnt,
                   e.spc, e.sif, e.fif, e.fid, e.frz, e.busy, e.done, e.cnt);
        end
      end
    end
  end

  initial begin
    stim_t s;
    stim_t idle;
    idle = '0;

    // Reset state.
    apply(idle, 1'b0);
    apply(idle, 1'b0);
    apply(idle, 1'b1);

    // lw $2 in EX, rs=2 in ID: one bubble, counter 0 -> 1.
    s = idle; s.mem_read = 1'b1; s.rt_ex = 5'd2; s.rs_id = 5'd2;
    apply(s, 1'b1);
    apply(idle, 1'b1);

    // Load into $0 never stalls; rt match ignored when rt is not read.
    s = idle; s.mem_read = 1'b1; s.rt_ex = 5'd0; s.rs_id = 5'd0;
    apply(s, 1'b1);
    s = idle; s.mem_read = 1'b1; s.rt_ex = 5'd2; s.rs_id = 5'd5; s.rt_id = 5'd2;
    apply(s, 1'b1);
    s.use_rt = 1'b1;
    apply(s, 1'b1);

    // Taken branch overrides load-use.
    s = idle; s.mem_read = 1'b1; s.rt_ex = 5'd3; s.rs_id = 5'd3; s.br = 1'b1;
    apply(s, 1'b1);

    // Divide issue, then mflo held in ID until it proceeds.
    s = idle; s.md_start = 1'b1; s.md_div = 1'b1;
    apply(s, 1'b1);
    s = idle; s.md_read = 1'b1;
    for (int i = 0; i < DIV_LAT + 1; i++) apply(s, 1'b1);

    // Branch during a 3-cycle memory wait, then the flush fires.
    s = idle; s.br = 1'b1; s.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) apply(s, 1'b1);
    s.mem_req = 1'b0;
    apply(s, 1'b1);
    apply(idle, 1'b1);

    // Back-to-back multiplies: second one issues in the MdDone cycle.
    s = idle; s.md_start = 1'b1;
    for (int i = 0; i < 2 * MUL_LAT + 2; i++) apply(s, 1'b1);
    apply(idle, 1'b1);

    // Abort a divide by reset at md_cnt = 10.
    s = idle; s.md_start = 1'b1; s.md_div = 1'b1;
    apply(s, 1'b1);
    for (int i = 0; i < 40 && md_left != 10; i++) apply(idle, 1'b1);
    apply(idle, 1'b0);
    apply(idle, 1'b0);
    apply(idle, 1'b1);

    // Randomised traffic with biased hit rates.
    for (int i = 0; i < 3000; i++) begin
      s.mem_read  = ($urandom_range(0, 2) == 0);
      s.rt_ex     = 5'($urandom_range(0, 3));
      s.rs_id     = 5'($urandom_range(0, 3));
      s.rt_id     = 5'($urandom_range(0, 3));
      s.use_rt    = $urandom_range(0, 1) != 0;
      s.br        = ($urandom_range(0, 7) == 0);
      s.md_start  = ($urandom_range(0, 5) == 0);
      s.md_div    = ($urandom_range(0, 3) == 0);
      s.md_read   = ($urandom_range(0, 4) == 0);
      s.mem_req   = ($urandom_range(0, 2) == 0);
      s.mem_ready = ($urandom_range(0, 2) != 0);
      apply(s, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
    end

    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    drv_done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives the stall/flush controls of PC, IF/ID and ID/EX: load-use bubbles, taken-branch flushes, interlocks on the multi-cycle mul/div unit, and whole-pipe freeze while data memory is not ready.
- Sits beside the decode stage and consumes ID/EX and MEM stage status.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- MUL_LAT, 4: EX-occupancy cycles of a multiply (>=2).
- DIV_LAT, 32: EX-occupancy cycles of a divide (>=2, >=MUL_LAT).
- CNT_W, 16: width of stall_cycles counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- MemRead_EX  in  1  instruction in EX is a load
- RT_EX  in  5  load destination register in EX
- RS_ID  in  5  rs of instruction in ID
- RT_ID  in  5  rt of instruction in ID
- UseRt_ID  in  1  ID instruction reads rt
- BranchTaken_EX  in  1  branch/jump resolved taken in EX
- MdStart_ID  in  1  ID instruction is mult/div
- MdIsDiv_ID  in  1  with MdStart_ID: 1=div, 0=mult
- MdRead_ID  in  1  ID instruction is mfhi/mflo
- MemReq_MEM  in  1  MEM stage performs a load/store
- MemReady_MEM  in  1  data memory completes this cycle
- StallPC  out  1  hold PC
- StallIFID  out  1  hold IF/ID
- FlushIFID  out  1  clear IF/ID
- FlushIDEX  out  1  load bubble into ID/EX (drives ID/EX flush)
- Freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- MdBusy  out  1  mul/div unit occupied (registered)
- MdDone  out  1  one-cycle pulse in last busy cycle
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset: state IDLE, md_cnt=0, stall_cycles=0, MdBusy=0. MdDone=0 in reset (gated by IDLE state). All stall/flush/Freeze outputs forced 0 while rst_n low.
- Stall/flush outputs are combinational from inputs and registered state, valid in the same cycle.
- Conditions:
  - mem_wait = MemReq_MEM & ~MemReady_MEM.
  - load_use = MemRead_EX & RT_EX!=0 & (RT_EX==RS_ID | (UseRt_ID & RT_EX==RT_ID)).
  - md_hz = MdBusy & (MdStart_ID | MdRead_ID), unless MdDone is high that cycle (result available next cycle).
- Priority, highest first:
  1. mem_wait: Freeze=StallPC=StallIFID=1; FlushIFID=FlushIDEX=0. Branch/load-use are evaluated again after release.
  2. BranchTaken_EX: FlushIFID=FlushIDEX=1, StallPC=StallIFID=0. Overrides load_use and md_hz.
  3. load_use | md_hz: StallPC=StallIFID=FlushIDEX=1, FlushIFID=0.
  4. Otherwise all 0.
- Mul/div FSM, states IDLE and BUSY:
  - Issue = MdStart_ID & no stall & no flush & ~mem_wait this cycle.
  - IDLE->BUSY on issue: md_cnt<=(MdIsDiv_ID?DIV_LAT:MUL_LAT)-1.
  - In BUSY, md_cnt decrements every cycle, including during mem_wait (the unit runs independently).
  - MdDone=1 when BUSY & md_cnt==1. At md_cnt==1 the next state is IDLE, unless an issue occurs that cycle; then reload and stay BUSY (back-to-back).
  - MdBusy=1 iff state==BUSY.
- stall_cycles increments when StallPC=1; holds at all-ones.
- rst_n low mid-operation aborts BUSY immediately; no MdDone is generated.

Test Plan:
- lw $2 in EX (MemRead_EX=1, RT_EX=2), RS_ID=2 -> StallPC=StallIFID=FlushIDEX=1 for 1 cycle; stall_cycles 0->1.
- load_use with RT_EX=0 -> no stall. UseRt_ID=0 with RT_ID match only -> no stall.
- BranchTaken_EX=1 together with load_use -> FlushIFID=FlushIDEX=1, StallPC=0.
- Divide issued (DIV_LAT=32), then mflo in ID next cycle -> MdBusy 31 cycles, stall 30 cycles, MdDone pulses in the last busy cycle, mflo proceeds the following cycle.
- MemReq_MEM=1, MemReady_MEM=0 for 3 cycles during a branch -> Freeze=1 for 3 cycles, no flush; flush fires the cycle after ready.
- Assert rst_n=0 at md_cnt=10 -> MdBusy=0 asynchronously, stall_cycles=0, no MdDone pulse.
